// File: rtl/msftdvip_cheri_dram_pkg.sv
// Shared types and constants for the CHERI data-RAM adapter.
// Holds scrub state encoding, address geometry and the response bundle.
package msftdvip_cheri_dram_pkg;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic [31:0] DRAM_BASE_DEFAULT = 32'h200f_0000;
    localparam int unsigned LANE_BITS         = 32;
    localparam int unsigned DWORD_BYTES       = 8;

    typedef struct packed {
        logic valid;
        logic err;
        logic rd;
        logic ts;
    } rsp_t;

    function automatic logic [7:0] lane_be(input logic hi, input logic [3:0] be);
        return hi ? {be, 4'h0} : {4'h0, be};
    endfunction

endpackage

// File: rtl/msftdvip_cheri_dram_adapter_if.sv
// Core-side data port of the CHERI data-RAM adapter.
// Request/grant/response bundle shared by the core and the adapter.
interface msftdvip_cheri_dram_adapter_if;

    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_we_i;
    logic        data_is_cap_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [64:0] data_wdata_i;
    logic [64:0] data_rdata_o;
    logic        data_err_o;

    modport master (
        output data_req_i, data_we_i, data_is_cap_i,
        output data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_we_i, data_is_cap_i,
        input  data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

endinterface

// File: rtl/msftdvip_cheri_dram_tag_scrub.sv
// Post-reset tag scrub: walks every SRAM word clearing its tag bit,
// yielding to TS-map reads, then hands the RAM to the data port.
module msftdvip_cheri_dram_tag_scrub
    import msftdvip_cheri_dram_pkg::*;
#(
    parameter int unsigned DramWords = 8192,
    localparam int unsigned AW = $clog2(DramWords)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          tsmap_cs_i,
    output logic          run_o,
    output logic          scrub_we_o,
    output logic [AW-1:0] scrub_addr_o,
    output logic          init_done_o
);

    localparam logic [0:0] ST_INIT = S_INIT;
    localparam logic [0:0] ST_RUN  = S_RUN;
    localparam logic [AW-1:0] LastWord = AW'(DramWords - 1);

    logic [0:0]    state_q;
    logic [AW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else if (state_q == ST_INIT && !tsmap_cs_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LastWord) begin
                state_q <= ST_RUN;
            end
        end
    end

    // Outputs are squashed while reset is held so nothing leaks to the SRAM.
    assign run_o        = (state_q == ST_RUN) && !rst_i;
    assign init_done_o  = run_o;
    assign scrub_we_o   = (state_q == ST_INIT) && !tsmap_cs_i && !rst_i;
    assign scrub_addr_o = cnt_q;

endmodule

// File: rtl/msftdvip_cheri_dram_adapter.sv
// CHERI data-RAM adapter: arbitrates core data port, TS-map reads and the
// tag scrub onto one 65-bit SRAM with a fixed one-cycle response.
module msftdvip_cheri_dram_adapter
    import msftdvip_cheri_dram_pkg::*;
#(
    parameter logic [31:0] DramBase  = DRAM_BASE_DEFAULT,
    parameter int unsigned DramWords = 8192,
    localparam int unsigned AW = $clog2(DramWords)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    msftdvip_cheri_dram_adapter_if.slave  dbus,
    input  logic                          tsmap_cs_i,
    input  logic [15:0]                   tsmap_addr_i,
    output logic [64:0]                   tsmap_rdata_o,
    output logic                          sram_cs_o,
    output logic                          sram_we_o,
    output logic                          sram_tag_we_o,
    output logic [AW-1:0]                 sram_addr_o,
    output logic [7:0]                    sram_be_o,
    output logic [64:0]                   sram_wdata_o,
    input  logic [64:0]                   sram_rdata_i,
    output logic                          init_done_o
);

    localparam logic [32:0] DramBytes = 33'(DramWords * DWORD_BYTES);

    logic          run;
    logic          scrub_we;
    logic [AW-1:0] scrub_addr;

    msftdvip_cheri_dram_tag_scrub #(
        .DramWords (DramWords)
    ) u_scrub (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .tsmap_cs_i   (tsmap_cs_i),
        .run_o        (run),
        .scrub_we_o   (scrub_we),
        .scrub_addr_o (scrub_addr),
        .init_done_o  (init_done_o)
    );

    logic [31:0] off;
    logic        in_range;
    logic        cap_bad;
    logic        gnt;
    logic        acc_ok;
    logic        ts_ok;
    logic        hi;
    logic        wr_tag_we;
    logic        wr_tag;
    logic        unused_bits;

    assign off      = dbus.data_addr_i - DramBase;
    assign in_range = (dbus.data_addr_i >= DramBase) && ({1'b0, off} < DramBytes);
    assign cap_bad  = dbus.data_is_cap_i && (dbus.data_addr_i[1:0] != 2'b00);
    assign gnt      = dbus.data_req_i && run && !tsmap_cs_i;
    assign acc_ok   = gnt && in_range && !cap_bad;
    assign ts_ok    = tsmap_cs_i && !rst_i
                   && (32'(tsmap_addr_i[15:1]) < DramWords);
    assign hi       = dbus.data_addr_i[2];

    // A capability covers the low word only; its upper half leaves the tag alone.
    assign wr_tag_we = !dbus.data_is_cap_i || !hi;
    assign wr_tag    = dbus.data_is_cap_i && !hi
                    && dbus.data_wdata_i[LANE_BITS];

    assign unused_bits = ^{dbus.data_wdata_i[64:33], tsmap_addr_i[0]};

    assign dbus.data_gnt_o = gnt;

    always_comb begin
        sram_cs_o     = 1'b0;
        sram_we_o     = 1'b0;
        sram_tag_we_o = 1'b0;
        sram_addr_o   = '0;
        sram_be_o     = '0;
        sram_wdata_o  = '0;
        if (ts_ok) begin
            sram_cs_o   = 1'b1;
            sram_addr_o = tsmap_addr_i[AW:1];
        end else if (scrub_we) begin
            sram_cs_o     = 1'b1;
            sram_we_o     = 1'b1;
            sram_tag_we_o = 1'b1;
            sram_addr_o   = scrub_addr;
        end else if (acc_ok) begin
            sram_cs_o   = 1'b1;
            sram_we_o   = dbus.data_we_i;
            sram_addr_o = dbus.data_addr_i[AW+2:3];
            if (dbus.data_we_i) begin
                sram_be_o     = lane_be(hi, dbus.data_be_i);
                sram_tag_we_o = wr_tag_we;
                sram_wdata_o  = {wr_tag,
                                 dbus.data_wdata_i[LANE_BITS-1:0],
                                 dbus.data_wdata_i[LANE_BITS-1:0]};
            end
        end
    end

    rsp_t rsp_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_q <= '0;
        end else begin
            rsp_q.valid <= gnt;
            rsp_q.err   <= gnt && !acc_ok;
            rsp_q.rd    <= acc_ok && !dbus.data_we_i;
            rsp_q.ts    <= ts_ok;
        end
    end

    assign dbus.data_rvalid_o = rsp_q.valid && !rst_i;
    assign dbus.data_err_o    = rsp_q.err && !rst_i;
    assign dbus.data_rdata_o  = (rsp_q.rd && !rst_i) ? sram_rdata_i : '0;
    assign tsmap_rdata_o      = (rsp_q.ts && !rst_i) ? sram_rdata_i : '0;

endmodule

// File: tb/tb_msftdvip_cheri_dram_adapter.sv
// Bench for the CHERI data-RAM adapter: SRAM model, reference memory
// model checked every cycle, plus directed literal checks.
module tb_msftdvip_cheri_dram_adapter;

    localparam int AW = 13;
    localparam int NW = 8192;
    localparam logic [31:0] BASE = 32'h200f_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          ts_cs;
    logic [15:0]   ts_addr;
    logic [64:0]   ts_rdata;
    logic          sram_cs;
    logic          sram_we;
    logic          sram_tag_we;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_be;
    logic [64:0]   sram_wdata;
    logic [64:0]   sram_rdata;
    logic          init_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    msftdvip_cheri_dram_adapter_if dbus ();

    msftdvip_cheri_dram_adapter dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .dbus          (dbus),
        .tsmap_cs_i    (ts_cs),
        .tsmap_addr_i  (ts_addr),
        .tsmap_rdata_o (ts_rdata),
        .sram_cs_o     (sram_cs),
        .sram_we_o     (sram_we),
        .sram_tag_we_o (sram_tag_we),
        .sram_addr_o   (sram_addr),
        .sram_be_o     (sram_be),
        .sram_wdata_o  (sram_wdata),
        .sram_rdata_i  (sram_rdata),
        .init_done_o   (init_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [64:0] init_word(input int i);
        return {1'b1, 32'hA500_0000 | 32'(i), 32'h5A00_0000 | 32'(i)};
    endfunction

    task automatic chk(input string nm, input logic [64:0] act,
                       input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // SRAM behavioural model
    logic [64:0] mem [NW];
    logic        mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < NW; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (sram_cs && sram_we) begin
            for (int b = 0; b < 8; b++)
                if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            if (sram_tag_we) mem[sram_addr][64] <= sram_wdata[64];
        end
        if (sram_cs && !sram_we) sram_rdata <= mem[sram_addr];
        else sram_rdata <= {1'b1, $urandom, $urandom};
    end

    // Reference model: what the outputs must be, from the adapter's rules
    logic [64:0] refm [NW];
    logic        ref_ready = 1'b0;
    logic        m_run;
    int          m_cnt;
    logic        p_v, p_err;
    logic [64:0] p_d, p_ts;

    always @(negedge clk) begin
        logic        e_gnt, e_cs, e_we, e_tw, e_tag, n_err, inr, bad;
        logic [7:0]  e_be;
        logic [63:0] e_wd;
        logic [64:0] n_d, n_ts;
        int          e_addr, w, tw;
        logic [31:0] a;
        if (!ref_ready) begin
            for (int i = 0; i < NW; i++) refm[i] = init_word(i);
            ref_ready = 1'b1;
        end
        if (rst) begin
            chk("rst_gnt", dbus.data_gnt_o, 0);
            chk("rst_rvalid", dbus.data_rvalid_o, 0);
            chk("rst_rdata", dbus.data_rdata_o, 0);
            chk("rst_cs", sram_cs, 0);
            chk("rst_done", init_done, 0);
            chk("rst_ts", ts_rdata, 0);
            m_run = 0; m_cnt = 0;
            p_v = 0; p_err = 0; p_d = '0; p_ts = '0;
        end else begin
            chk("m_rvalid", dbus.data_rvalid_o, p_v);
            chk("m_err", dbus.data_err_o, p_err);
            chk("m_rdata", dbus.data_rdata_o, p_d);
            chk("m_ts_rdata", ts_rdata, p_ts);
            chk("m_done", init_done, m_run);
            e_gnt = dbus.data_req_i && m_run && !ts_cs;
            chk("m_gnt", dbus.data_gnt_o, e_gnt);
            e_cs = 0; e_we = 0; e_tw = 0; e_tag = 0; e_be = '0;
            e_wd = '0; e_addr = 0; n_err = 0; n_d = '0; n_ts = '0;
            if (ts_cs) begin
                tw = int'(ts_addr) / 2;
                if (tw < NW) begin
                    e_cs = 1; e_addr = tw; n_ts = refm[tw];
                end
            end else if (!m_run) begin
                e_cs = 1; e_we = 1; e_tw = 1; e_addr = m_cnt;
                refm[m_cnt][64] = 1'b0;
                m_cnt++;
                if (m_cnt == NW) m_run = 1;
            end else if (dbus.data_req_i) begin
                a   = dbus.data_addr_i;
                inr = a >= BASE && a < BASE + 32'(NW * 8);
                bad = dbus.data_is_cap_i && a[1:0] != 2'b00;
                if (!inr || bad) begin
                    n_err = 1;
                end else begin
                    w = int'(a - BASE) / 8;
                    e_cs = 1; e_addr = w; e_we = dbus.data_we_i;
                    if (!e_we) begin
                        n_d = refm[w];
                    end else begin
                        e_be  = a[2] ? {dbus.data_be_i, 4'h0} : {4'h0, dbus.data_be_i};
                        e_tw  = !dbus.data_is_cap_i || !a[2];
                        e_tag = dbus.data_is_cap_i && !a[2] && dbus.data_wdata_i[32];
                        e_wd  = {2{dbus.data_wdata_i[31:0]}};
                        for (int b = 0; b < 8; b++)
                            if (e_be[b]) refm[w][b*8 +: 8] = e_wd[b*8 +: 8];
                        if (e_tw) refm[w][64] = e_tag;
                    end
                end
            end
            chk("m_cs", sram_cs, e_cs);
            if (e_cs) begin
                chk("m_addr", 65'(sram_addr), 65'(e_addr));
                chk("m_we", sram_we, e_we);
                chk("m_tag_we", sram_tag_we, e_tw);
                if (e_we) chk("m_be", sram_be, e_be);
                if (e_tw) chk("m_tag", sram_wdata[64], e_tag);
                if (e_we && m_run) chk("m_wdata", sram_wdata[63:0], e_wd);
            end
            p_v = e_gnt; p_err = n_err; p_d = n_d; p_ts = n_ts;
        end
    end

    // Directed stimulus
    task automatic do_acc(input logic we, input logic cap, input logic [3:0] be,
                          input logic [31:0] addr, input logic [64:0] wd,
                          output int gcyc, output logic [7:0] gbe,
                          output logic gcs, output logic gtw);
        int n = 0;
        dbus.data_req_i = 1; dbus.data_we_i = we; dbus.data_is_cap_i = cap;
        dbus.data_be_i = be; dbus.data_addr_i = addr; dbus.data_wdata_i = wd;
        gcyc = 0; gbe = '0; gcs = 0; gtw = 0;
        forever begin
            @(negedge clk);
            if (dbus.data_gnt_o) begin
                gcyc = cyc; gbe = sram_be; gcs = sram_cs; gtw = sram_tag_we;
                break;
            end
            n++;
            if (n > 20000) begin
                chk("gnt_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        dbus.data_req_i = 0;
    endtask

    task automatic get_rsp(output logic v, output logic e, output logic [64:0] d);
        @(negedge clk);
        v = dbus.data_rvalid_o; e = dbus.data_err_o; d = dbus.data_rdata_o;
    endtask

    initial begin
        int          t0, g;
        int          gc [4];
        logic [7:0]  gb [4];
        logic [7:0]  b8;
        logic        cs, tw, v, e;
        logic [64:0] d;
        rst = 1; ts_cs = 0; ts_addr = '0;
        dbus.data_req_i = 0; dbus.data_we_i = 0; dbus.data_is_cap_i = 0;
        dbus.data_be_i = '0; dbus.data_addr_i = '0; dbus.data_wdata_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("lit_rst_done", init_done, 0);
        @(posedge clk); #1;
        rst = 0;
        t0 = cyc;
        @(negedge clk);
        chk("lit_scrub0_cs", {sram_cs, sram_we, sram_tag_we}, 3'b111);
        chk("lit_scrub0_addr", 65'(sram_addr), 0);
        chk("lit_scrub0_be", sram_be, 0);
        @(posedge clk); #1;
        // read held through the scrub, granted on the first RUN cycle
        do_acc(0, 0, 4'hF, 32'h200f_0010, '0, g, b8, cs, tw);
        chk("lit_init_gnt_cyc", 65'(g - t0), 65'(NW));
        get_rsp(v, e, d);
        chk("lit_init_rd", d, {1'b0, 32'hA500_0002, 32'h5A00_0002});

        do_acc(1, 1, 4'hF, 32'h200f_0010, {32'h0, 1'b1, 32'hCAFE_0001}, g, b8, cs, tw);
        chk("lit_capwr_tagwe", tw, 1);
        get_rsp(v, e, d);
        chk("lit_capwr_rsp", {v, e, d}, {2'b10, 65'h0});
        do_acc(0, 1, 4'hF, 32'h200f_0010, '0, g, b8, cs, tw);
        get_rsp(v, e, d);
        chk("lit_cap_tag1", d, {1'b1, 32'hA500_0002, 32'hCAFE_0001});
        do_acc(1, 0, 4'hF, 32'h200f_0014, {33'h0, 32'hCAFE_0002}, g, b8, cs, tw);
        get_rsp(v, e, d);
        do_acc(0, 0, 4'hF, 32'h200f_0010, '0, g, b8, cs, tw);
        get_rsp(v, e, d);
        chk("lit_word_tag0", d, {1'b0, 32'hCAFE_0002, 32'hCAFE_0001});
        do_acc(1, 1, 4'hF, 32'h200f_0014, {32'h0, 1'b1, 32'h1234_5678}, g, b8, cs, tw);
        chk("lit_caphi_tagwe", tw, 0);
        get_rsp(v, e, d);

        do_acc(0, 0, 4'hF, 32'h2010_0000, '0, g, b8, cs, tw);
        chk("lit_oor_cs", cs, 0);
        get_rsp(v, e, d);
        chk("lit_oor_rsp", {v, e, d}, {2'b11, 65'h0});
        do_acc(0, 1, 4'hF, 32'h200f_0011, '0, g, b8, cs, tw);
        get_rsp(v, e, d);
        chk("lit_capmis_rsp", {v, e, d}, {2'b11, 65'h0});

        ts_cs = 1; ts_addr = 16'h3801;
        dbus.data_req_i = 1; dbus.data_we_i = 0; dbus.data_is_cap_i = 0;
        dbus.data_addr_i = 32'h200f_0008;
        @(negedge clk);
        chk("lit_ts_gnt", dbus.data_gnt_o, 0);
        chk("lit_ts_addr", 65'(sram_addr), 65'h1C00);
        @(posedge clk); #1;
        ts_cs = 0;
        @(negedge clk);
        chk("lit_ts_rdata", ts_rdata, {1'b0, 32'hA500_1C00, 32'h5A00_1C00});
        chk("lit_ts_gnt_next", dbus.data_gnt_o, 1);
        @(posedge clk); #1;
        dbus.data_req_i = 0;
        get_rsp(v, e, d);
        chk("lit_ts_after_rd", d, {1'b0, 32'hA500_0001, 32'h5A00_0001});

        ts_cs = 1; ts_addr = 16'hC000;
        @(negedge clk);
        chk("lit_ts_oor_cs", sram_cs, 0);
        @(posedge clk); #1;
        ts_cs = 0;
        @(negedge clk);
        chk("lit_ts_oor_rdata", ts_rdata, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            do_acc(1, 0, 4'h1, 32'h200f_0000 + 32'(4 * i),
                   65'(32'h11 * (i + 1)), gc[i], gb[i], cs, tw);
        end
        get_rsp(v, e, d);
        chk("lit_b2b_be0", gb[0], 8'h01);
        chk("lit_b2b_be1", gb[1], 8'h10);
        chk("lit_b2b_be2", gb[2], 8'h01);
        chk("lit_b2b_be3", gb[3], 8'h10);
        chk("lit_b2b_cyc", 65'(gc[3] - gc[0]), 3);
        do_acc(0, 0, 4'hF, 32'h200f_0000, '0, g, b8, cs, tw);
        get_rsp(v, e, d);
        chk("lit_b2b_w0", d, {1'b0, 32'hA500_0022, 32'h5A00_0011});
        do_acc(0, 0, 4'hF, 32'h200f_0008, '0, g, b8, cs, tw);
        get_rsp(v, e, d);
        chk("lit_b2b_w1", d, {1'b0, 32'hA500_0044, 32'h5A00_0033});

        dbus.data_req_i = 1; dbus.data_we_i = 0; dbus.data_is_cap_i = 0;
        dbus.data_addr_i = 32'h200f_0000;
        @(negedge clk);
        chk("lit_rstmid_gnt", dbus.data_gnt_o, 1);
        @(posedge clk); #1;
        dbus.data_req_i = 0;
        rst = 1;
        @(negedge clk);
        chk("lit_rstmid_rv0", dbus.data_rvalid_o, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("lit_rstmid_rv1", dbus.data_rvalid_o, 0);
        chk("lit_rescrub_addr0", 65'(sram_addr), 0);
        chk("lit_rescrub_we", {sram_cs, sram_we, sram_tag_we}, 3'b111);
        @(negedge clk);
        chk("lit_rescrub_addr1", 65'(sram_addr), 1);
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
